// File: rtl/ca_regfile.sv
// ca_regfile: bus register file with grant FSM, CA engine control, generation counter and dual-port seed RAM
module ca_regfile #(
    parameter logic [7:0]  ID_VALUE   = 8'hCA,
    parameter logic [7:0]  RULE_RESET = 8'd30,
    parameter int          SEED_AW    = 6,
    parameter logic [15:0] SEED_BASE  = 16'h1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        int_address,
    input  logic [7:0]         int_wr_data,
    input  logic               int_write,
    input  logic               int_read,
    output logic [7:0]         int_rd_data,
    input  logic               int_req,
    output logic               int_gnt,
    output logic               ca_run,
    output logic               ca_step,
    output logic               ca_clear,
    output logic [7:0]         ca_rule,
    input  logic               gen_tick,
    input  logic [SEED_AW-1:0] seed_rd_addr,
    output logic [7:0]         seed_rd_data
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_next;
    logic [7:0] seed_mem [1<<SEED_AW];
    logic [15:0] gen;
    logic [7:0] gen_hi, rd_mux;
    logic wrap_flag, wrap_evt, wr, rd, seed_hit, ctrl_wr, rule_wr, status_rd, gen_lo_rd;
    logic [SEED_AW-1:0] seed_idx;

    assign int_gnt   = state == GRANT;
    assign wr        = int_write && int_gnt;
    assign rd        = int_read && int_gnt;
    assign seed_hit  = int_address[15:SEED_AW] == SEED_BASE[15:SEED_AW];
    assign seed_idx  = int_address[SEED_AW-1:0];
    assign ctrl_wr   = wr && int_address == 16'h0001;
    assign rule_wr   = wr && int_address == 16'h0002;
    assign status_rd = rd && int_address == 16'h0003;
    assign gen_lo_rd = rd && int_address == 16'h0004;
    assign wrap_evt  = gen_tick && gen == 16'hFFFF && !ca_clear;

    always_comb begin
        state_next = int_req ? GRANT : IDLE;
        rd_mux = seed_hit                 ? seed_mem[seed_idx] :
                 int_address == 16'h0000  ? ID_VALUE :
                 int_address == 16'h0001  ? {7'd0, ca_run} :
                 int_address == 16'h0002  ? ca_rule :
                 int_address == 16'h0003  ? {6'd0, wrap_flag | wrap_evt, ca_run} :
                 int_address == 16'h0004  ? gen[7:0] :
                 int_address == 16'h0005  ? gen_hi : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            int_rd_data  <= 8'h00;
            ca_run       <= 1'b0;
            ca_step      <= 1'b0;
            ca_clear     <= 1'b0;
            ca_rule      <= RULE_RESET;
            gen          <= 16'h0000;
            gen_hi       <= 8'h00;
            wrap_flag    <= 1'b0;
            seed_rd_data <= 8'h00;
        end else begin
            state        <= state_next;
            int_rd_data  <= rd ? rd_mux : int_rd_data;
            ca_run       <= ctrl_wr ? int_wr_data[0] : ca_run;
            ca_step      <= ctrl_wr && int_wr_data[1];
            ca_clear     <= ctrl_wr && int_wr_data[2];
            ca_rule      <= rule_wr ? int_wr_data : ca_rule;
            seed_rd_data <= seed_mem[seed_rd_addr];
            // soft clear outranks a coincident tick and the GEN_HI latch
            gen          <= ca_clear ? 16'h0000 : gen_tick ? gen + 16'd1 : gen;
            gen_hi       <= ca_clear ? 8'h00 : gen_lo_rd ? gen[15:8] : gen_hi;
            wrap_flag    <= !ca_clear && (wrap_evt || (wrap_flag && !status_rd));
        end
    end

    always_ff @(posedge clock)
        if (wr && seed_hit) seed_mem[seed_idx] <= int_wr_data;
endmodule

// File: tb/tb_ca_regfile.sv
// tb_ca_regfile: directed self-checking bench for ca_regfile
module tb_ca_regfile;
    logic        clock = 0, reset = 1;
    logic [15:0] int_address = 0;
    logic [7:0]  int_wr_data = 0, int_rd_data, ca_rule, seed_rd_data;
    logic        int_write = 0, int_read = 0, int_req = 0, int_gnt;
    logic        ca_run, ca_step, ca_clear, gen_tick = 0;
    logic [5:0]  seed_rd_addr = 0;
    int          n_checks = 0, n_fail = 0;
    logic [7:0]  d;

    ca_regfile dut (
        .clock(clock), .reset(reset), .int_address(int_address), .int_wr_data(int_wr_data),
        .int_write(int_write), .int_read(int_read), .int_rd_data(int_rd_data),
        .int_req(int_req), .int_gnt(int_gnt), .ca_run(ca_run), .ca_step(ca_step),
        .ca_clear(ca_clear), .ca_rule(ca_rule), .gen_tick(gen_tick),
        .seed_rd_addr(seed_rd_addr), .seed_rd_data(seed_rd_data)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
        int_address = a; int_wr_data = v; int_write = 1;
        cyc();
        int_write = 0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
        int_address = a; int_read = 1;
        cyc();
        int_read = 0;
        v = int_rd_data;
    endtask

    task automatic ticks(input int n);
        gen_tick = 1;
        repeat (n) cyc();
        gen_tick = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) cyc();
        n_checks++;
        if ({int_gnt, int_rd_data, ca_run, ca_step, ca_clear, ca_rule, seed_rd_data} !== {1'b0, 8'h00, 3'b000, 8'd30, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b rd=%h run=%b step=%b clr=%b rule=%h seed=%h, want 0 00 0 0 0 1e 00",
                     int_gnt, int_rd_data, ca_run, ca_step, ca_clear, ca_rule, seed_rd_data);
        end
        reset = 0;
    endtask

    task automatic test_grant();
        int_req = 1;
        cyc();
        n_checks++;
        if (int_gnt !== 1'b1) begin n_fail++; $display("FAIL grant_rise: got %b want 1", int_gnt); end
        bus_read(16'h0000, d);
        n_checks++;
        if (d !== 8'hCA) begin n_fail++; $display("FAIL read_id: got %h want ca", d); end
        int_req = 0;
        cyc();
        n_checks++;
        if (int_gnt !== 1'b0) begin n_fail++; $display("FAIL grant_fall: got %b want 0", int_gnt); end
        int_req = 1;
        cyc();
    endtask

    task automatic test_regs();
        bus_write(16'h0002, 8'h6E);
        n_checks++;
        if (ca_rule !== 8'h6E) begin n_fail++; $display("FAIL rule_write: got %h want 6e", ca_rule); end
        bus_read(16'h0002, d);
        n_checks++;
        if (d !== 8'h6E) begin n_fail++; $display("FAIL rule_read: got %h want 6e", d); end
        bus_write(16'h0003, 8'hFF);
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 8'h00 || ca_rule !== 8'h6E) begin n_fail++; $display("FAIL status_ro: got %h rule %h want 00 6e", d, ca_rule); end
        bus_read(16'h7777, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h want 00", d); end
    endtask

    task automatic test_ctrl();
        bus_write(16'h0001, 8'h03);
        n_checks++;
        if (ca_run !== 1'b1 || ca_step !== 1'b1) begin n_fail++; $display("FAIL step_pulse: got run=%b step=%b want 1 1", ca_run, ca_step); end
        cyc();
        n_checks++;
        if (ca_run !== 1'b1 || ca_step !== 1'b0) begin n_fail++; $display("FAIL step_end: got run=%b step=%b want 1 0", ca_run, ca_step); end
        bus_read(16'h0001, d);
        n_checks++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL ctrl_read: got %h want 01", d); end
    endtask

    task automatic test_gen();
        ticks(300);
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 8'h2C) begin n_fail++; $display("FAIL gen_lo: got %h want 2c", d); end
        ticks(5);
        bus_read(16'h0005, d);
        n_checks++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL gen_hi_latched: got %h want 01", d); end
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 8'h31) begin n_fail++; $display("FAIL gen_lo_live: got %h want 31", d); end
    endtask

    task automatic test_wrap();
        bus_write(16'h0001, 8'h05);
        n_checks++;
        if (ca_clear !== 1'b1 || ca_run !== 1'b1) begin n_fail++; $display("FAIL clear_pulse: got clr=%b run=%b want 1 1", ca_clear, ca_run); end
        cyc();
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL gen_cleared: got %h want 00", d); end
        ticks(65535);
        bus_read(16'h0004, d);
        bus_read(16'h0005, d);
        n_checks++;
        if (d !== 8'hFF) begin n_fail++; $display("FAIL gen_ffff_hi: got %h want ff", d); end
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL status_nowrap: got %h want 01", d); end
        ticks(1);
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL status_wrap: got %h want 03", d); end
        bus_read(16'h0003, d);
        n_checks++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL status_sticky_clear: got %h want 01", d); end
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL gen_wrapped: got %h want 00", d); end
        ticks(3);
        bus_write(16'h0001, 8'h05);
        ticks(1);
        bus_read(16'h0004, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL clear_beats_tick: got %h want 00", d); end
    endtask

    task automatic test_seed();
        bus_write(16'h1005, 8'h11);
        seed_rd_addr = 6'd5;
        cyc();
        bus_write(16'h1005, 8'hA5);
        n_checks++;
        if (seed_rd_data !== 8'h11) begin n_fail++; $display("FAIL seed_old_data: got %h want 11", seed_rd_data); end
        cyc();
        n_checks++;
        if (seed_rd_data !== 8'hA5) begin n_fail++; $display("FAIL seed_new_data: got %h want a5", seed_rd_data); end
        bus_read(16'h1005, d);
        n_checks++;
        if (d !== 8'hA5) begin n_fail++; $display("FAIL seed_bus_read: got %h want a5", d); end
        int_req = 0;
        cyc();
        bus_write(16'h1005, 8'hFF);
        bus_write(16'h0002, 8'h00);
        bus_read(16'h0000, d);
        n_checks++;
        if (ca_rule !== 8'h6E || d !== 8'hA5) begin n_fail++; $display("FAIL nogrant_ignored: got rule=%h rd=%h want 6e a5", ca_rule, d); end
        int_req = 1;
        cyc();
        bus_read(16'h1005, d);
        n_checks++;
        if (d !== 8'hA5) begin n_fail++; $display("FAIL nogrant_seed: got %h want a5", d); end
    endtask

    task automatic test_reset_mid();
        bus_write(16'h0001, 8'h07);
        reset = 1;
        cyc();
        n_checks++;
        if ({int_gnt, ca_run, ca_step, ca_clear, ca_rule} !== {4'b0000, 8'd30}) begin
            n_fail++;
            $display("FAIL reset_mid: got gnt=%b run=%b step=%b clr=%b rule=%h want 0 0 0 0 1e",
                     int_gnt, ca_run, ca_step, ca_clear, ca_rule);
        end
        reset = 0;
        int_req = 0;
    endtask

    initial begin
        test_reset();
        test_grant();
        test_regs();
        test_ctrl();
        test_gen();
        test_wrap();
        test_seed();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
